// File: rtl/color_filter_pipe.sv
// color_filter_pipe: two-stage RGB filter (remove / isolate / invert / saturate)
// with a valid/ready handshake. Configuration changes are shadowed and take effect
// only on a start-of-frame pixel, so a frame is never split between two settings.
module color_filter_pipe #(
    parameter int COLOR_WIDTH     = 4,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 modeIn,
    input  logic [2:0]                 colorSelect,
    input  logic                       cfgLoad,
    input  logic                       validIn,
    output logic                       readyOut,
    input  logic                       sofIn,
    input  logic [COLOR_WIDTH-1:0]     rIn,
    input  logic [COLOR_WIDTH-1:0]     gIn,
    input  logic [COLOR_WIDTH-1:0]     bIn,
    output logic                       validOut,
    input  logic                       readyIn,
    output logic                       sofOut,
    output logic [COLOR_WIDTH-1:0]     rOut,
    output logic [COLOR_WIDTH-1:0]     gOut,
    output logic [COLOR_WIDTH-1:0]     bOut,
    output logic                       cfgPending,
    output logic [FRAME_CNT_WIDTH-1:0] frameCount
);

    typedef enum logic {WAIT_SOF, IN_STREAM} state_t;

    localparam logic [1:0] MODE_REMOVE  = 2'd0;
    localparam logic [1:0] MODE_ISOLATE = 2'd1;
    localparam logic [1:0] MODE_INVERT  = 2'd2;

    state_t state_q, state_d;

    // Active and shadow configuration; *_apply is what the accepted pixel carries.
    logic [1:0] mode_act_q, mode_act_d, mode_pend_q, mode_pend_d, mode_apply;
    logic [2:0] sel_act_q, sel_act_d, sel_pend_q, sel_pend_d, sel_apply;
    logic       pend_q, pend_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    // Pixels are packed with index 2 = R, 1 = G, 0 = B so index gi lines up
    // with colorSelect bit gi.
    logic [2:0][COLOR_WIDTH-1:0] pix_in, pix1_q, pix_filt, pix2_q;
    logic       v1_q, sof1_q, v2_q, sof2_q;
    logic [1:0] mode1_q;
    logic [2:0] sel1_q;

    logic en1, en2, accept;

    // Stage 2 advances when its content leaves or it is empty; stage 1 advances
    // when stage 2 makes room or stage 1 is empty (bubbles collapse).
    assign en2      = readyIn || !v2_q;
    assign en1      = en2 || !v1_q;
    assign readyOut = en1;
    assign accept   = validIn && en1;
    assign pix_in   = {rIn, gIn, bIn};

    // Per-channel operation; invert of c equals MAX - c, i.e. the bitwise complement.
    function automatic logic [COLOR_WIDTH-1:0] filter_chan(
        input logic [COLOR_WIDTH-1:0] c,
        input logic                   s,
        input logic [1:0]             m
    );
        logic [COLOR_WIDTH-1:0] res;
        res = c;
        case (m)
            MODE_REMOVE:  res = s ? '0 : c;
            MODE_ISOLATE: res = s ? c : '0;
            MODE_INVERT:  res = s ? ~c : c;
            default:      res = s ? '1 : c;
        endcase
        return res;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign pix_filt[gi] = filter_chan(pix1_q[gi], sel1_q[gi], mode1_q);
    end

    // Next-state, config selection for the accepted pixel, and shadow handling.
    always_comb begin
        state_d     = state_q;
        mode_act_d  = mode_act_q;
        sel_act_d   = sel_act_q;
        mode_pend_d = mode_pend_q;
        sel_pend_d  = sel_pend_q;
        pend_d      = pend_q;
        mode_apply  = mode_act_q;
        sel_apply   = sel_act_q;

        if (accept && sofIn && cfgLoad) begin
            mode_apply = modeIn;
            sel_apply  = colorSelect;
            mode_act_d = modeIn;
            sel_act_d  = colorSelect;
            pend_d     = 1'b0;
        end else if (accept && sofIn && pend_q) begin
            mode_apply = mode_pend_q;
            sel_apply  = sel_pend_q;
            mode_act_d = mode_pend_q;
            sel_act_d  = sel_pend_q;
            pend_d     = 1'b0;
        end else if (cfgLoad) begin
            if (state_q == WAIT_SOF) begin
                mode_act_d = modeIn;
                sel_act_d  = colorSelect;
            end else begin
                mode_pend_d = modeIn;
                sel_pend_d  = colorSelect;
                pend_d      = 1'b1;
            end
        end

        if (accept) begin
            state_d = IN_STREAM;
        end
    end

    // Control state: FSM, active/shadow config and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_SOF;
            mode_act_q  <= 2'd0;
            sel_act_q   <= 3'b000;
            mode_pend_q <= 2'd0;
            sel_pend_q  <= 3'b000;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_act_q  <= mode_act_d;
            sel_act_q   <= sel_act_d;
            mode_pend_q <= mode_pend_d;
            sel_pend_q  <= sel_pend_d;
            pend_q      <= pend_d;
            if (accept && sofIn) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // Pipeline: stage 1 holds the raw pixel with its config, stage 2 the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            pix1_q  <= '0;
            mode1_q <= 2'd0;
            sel1_q  <= 3'b000;
            v2_q    <= 1'b0;
            sof2_q  <= 1'b0;
            pix2_q  <= '0;
        end else begin
            if (en1) begin
                v1_q    <= validIn;
                sof1_q  <= validIn && sofIn;
                pix1_q  <= pix_in;
                mode1_q <= mode_apply;
                sel1_q  <= sel_apply;
            end
            if (en2) begin
                v2_q   <= v1_q;
                sof2_q <= v1_q && sof1_q;
                pix2_q <= pix_filt;
            end
        end
    end

    assign validOut   = v2_q;
    assign sofOut     = sof2_q;
    assign rOut       = pix2_q[2];
    assign gOut       = pix2_q[1];
    assign bOut       = pix2_q[0];
    assign cfgPending = pend_q;
    assign frameCount = frame_cnt_q;

endmodule

// File: tb/tb_color_filter_pipe.sv
// Directed bench for color_filter_pipe: reset, latency/throughput, modes,
// frame-boundary shadowing, backpressure with a scoreboard, async reset, wrap.
module tb_color_filter_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] modeIn;
    logic [2:0] colorSelect;
    logic       cfgLoad, validIn, readyOut, sofIn, validOut, readyIn, sofOut, cfgPending;
    logic [3:0] rIn, gIn, bIn, rOut, gOut, bOut;
    logic [7:0] frameCount;

    // Second instance: wide channels, narrow frame counter.
    logic [1:0] modeIn2;
    logic [2:0] colorSelect2;
    logic       cfgLoad2, validIn2, readyOut2, sofIn2, validOut2, readyIn2, sofOut2, cfgPending2;
    logic [7:0] rIn2, gIn2, bIn2, rOut2, gOut2, bOut2;
    logic [1:0] frameCount2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    color_filter_pipe #(.COLOR_WIDTH(4), .FRAME_CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .modeIn(modeIn), .colorSelect(colorSelect),
        .cfgLoad(cfgLoad), .validIn(validIn), .readyOut(readyOut), .sofIn(sofIn),
        .rIn(rIn), .gIn(gIn), .bIn(bIn), .validOut(validOut), .readyIn(readyIn),
        .sofOut(sofOut), .rOut(rOut), .gOut(gOut), .bOut(bOut),
        .cfgPending(cfgPending), .frameCount(frameCount)
    );

    color_filter_pipe #(.COLOR_WIDTH(8), .FRAME_CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .modeIn(modeIn2), .colorSelect(colorSelect2),
        .cfgLoad(cfgLoad2), .validIn(validIn2), .readyOut(readyOut2), .sofIn(sofIn2),
        .rIn(rIn2), .gIn(gIn2), .bIn(bIn2), .validOut(validOut2), .readyIn(readyIn2),
        .sofOut(sofOut2), .rOut(rOut2), .gOut(gOut2), .bOut(bOut2),
        .cfgPending(cfgPending2), .frameCount(frameCount2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        validIn = 1'b0;
        sofIn   = 1'b0;
        cfgLoad = 1'b0;
    endtask

    task automatic load_cfg(input logic [1:0] m, input logic [2:0] s);
        cfgLoad = 1'b1; modeIn = m; colorSelect = s;
        @(posedge clk); #1;
        cfgLoad = 1'b0;
    endtask

    // One isolated pixel with readyIn=1: presented in cycle k, on the output in cycle k+2.
    task automatic pix_single(input string tag, input logic sof,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                              input logic load, input logic [1:0] m, input logic [2:0] s,
                              input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
        validIn = 1'b1; sofIn = sof; rIn = r; gIn = g; bIn = b;
        cfgLoad = load; modeIn = m; colorSelect = s;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        check(tag, {validOut, sofOut, rOut, gOut, bOut}, {1'b1, sof, er, eg, eb});
    endtask

    logic [11:0] tp_pix [4];
    logic [12:0] exp_q [$];
    logic [12:0] hold_val;
    logic        stall_prev;
    logic [3:0]  nr, ng, nb;
    int          sent, rcv, cyc;
    logic [7:0]  w_in [5];
    logic [7:0]  w_exp [5];

    initial begin
        reset = 1'b1; readyIn = 1'b1; modeIn = 2'd0; colorSelect = 3'b000;
        rIn = '0; gIn = '0; bIn = '0;
        idle();
        modeIn2 = 2'd0; colorSelect2 = 3'b000; cfgLoad2 = 1'b0; validIn2 = 1'b0;
        sofIn2 = 1'b0; readyIn2 = 1'b1; rIn2 = '0; gIn2 = '0; bIn2 = '0;

        // ---- reset state ----
        #1;
        check("reset_outputs", {validOut, sofOut, rOut, gOut, bOut, cfgPending}, 32'h0);
        check("reset_frame_count", frameCount, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ready_after_reset", readyOut, 32'h1);
        check("valid_after_reset", validOut, 32'h0);

        // ---- pass-through, latency and throughput ----
        tp_pix[0] = 12'hA53; tp_pix[1] = 12'hB64; tp_pix[2] = 12'hC75; tp_pix[3] = 12'hD86;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                validIn = 1'b1; sofIn = (i == 0);
                {rIn, gIn, bIn} = tp_pix[i];
            end else begin
                idle();
            end
            #1;
            if (i < 2) begin
                check("latency_not_early", validOut, 32'h0);
            end else begin
                check("thru_pixel", {validOut, sofOut, rOut, gOut, bOut},
                      {1'b1, (i == 2), tp_pix[i-2]});
            end
            check("thru_ready", readyOut, 32'h1);
            @(posedge clk); #1;
        end
        check("frame_count_1", frameCount, 32'd1);

        // ---- each mode, loaded together with an SOF pixel ----
        pix_single("mode_remove",   1'b1, 4'h3, 4'hC, 4'h7, 1'b1, 2'd0, 3'b101, 4'h0, 4'hC, 4'h0);
        pix_single("mode_isolate",  1'b1, 4'h3, 4'hC, 4'h7, 1'b1, 2'd1, 3'b101, 4'h3, 4'h0, 4'h7);
        pix_single("mode_invert",   1'b1, 4'h3, 4'hC, 4'h7, 1'b1, 2'd2, 3'b101, 4'hC, 4'hC, 4'h8);
        pix_single("mode_saturate", 1'b1, 4'h3, 4'hC, 4'h7, 1'b1, 2'd3, 3'b101, 4'hF, 4'hC, 4'hF);
        check("frame_count_5", frameCount, 32'd5);
        check("no_pending_after_sim_load", cfgPending, 32'h0);

        // ---- shadowing: mid-frame load waits for the next SOF ----
        pix_single("mid_frame_before", 1'b0, 4'h3, 4'hC, 4'h7, 1'b0, 2'd0, 3'b000, 4'hF, 4'hC, 4'hF);
        load_cfg(2'd0, 3'b111);
        check("pending_set", cfgPending, 32'h1);
        pix_single("mid_frame_after_load", 1'b0, 4'h3, 4'hC, 4'h7, 1'b0, 2'd0, 3'b000, 4'hF, 4'hC, 4'hF);
        check("pending_held_mid_frame", cfgPending, 32'h1);
        pix_single("sof_applies_shadow", 1'b1, 4'hA, 4'h5, 4'h3, 1'b0, 2'd0, 3'b000, 4'h0, 4'h0, 4'h0);
        check("pending_cleared_on_sof", cfgPending, 32'h0);
        pix_single("after_sof_new_cfg", 1'b0, 4'hA, 4'h5, 4'h3, 1'b0, 2'd0, 3'b000, 4'h0, 4'h0, 4'h0);
        check("frame_count_6", frameCount, 32'd6);

        // ---- two loads before SOF: last one wins ----
        load_cfg(2'd2, 3'b100);
        load_cfg(2'd1, 3'b010);
        check("pending_double_load", cfgPending, 32'h1);
        pix_single("last_load_wins", 1'b1, 4'h3, 4'hC, 4'h7, 1'b0, 2'd0, 3'b000, 4'h0, 4'hC, 4'h0);
        pix_single("last_load_next", 1'b0, 4'h5, 4'h6, 4'h7, 1'b0, 2'd0, 3'b000, 4'h0, 4'h6, 4'h0);
        check("frame_count_7", frameCount, 32'd7);

        // ---- stall fill, output hold, then asynchronous reset mid-stream ----
        load_cfg(2'd3, 3'b111);
        check("pending_before_reset", cfgPending, 32'h1);
        readyIn = 1'b0;
        validIn = 1'b1; sofIn = 1'b0; {rIn, gIn, bIn} = 12'h123;
        @(posedge clk); #1;
        {rIn, gIn, bIn} = 12'h456;
        @(posedge clk); #1;
        {rIn, gIn, bIn} = 12'h789;
        check("stall_ready_low", readyOut, 32'h0);
        check("stall_out_first", {validOut, rOut, gOut, bOut}, {1'b1, 12'h020});
        @(posedge clk); #1;
        check("stall_out_hold", {validOut, rOut, gOut, bOut}, {1'b1, 12'h020});
        check("stall_ready_still_low", readyOut, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {validOut, sofOut, rOut, gOut, bOut, cfgPending}, 32'h0);
        check("async_reset_frame_count", frameCount, 32'h0);
        idle(); readyIn = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("ready_after_async_reset", readyOut, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_stale_pixel", validOut, 32'h0);
        end
        pix_single("passthrough_after_reset", 1'b0, 4'h3, 4'hC, 4'h7, 1'b0, 2'd0, 3'b000, 4'h3, 4'hC, 4'h7);

        // ---- randomized backpressure against a scoreboard ----
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        load_cfg(2'd2, 3'b010);          // WAIT_SOF: goes straight to active
        check("wait_sof_load_direct", cfgPending, 32'h0);
        sent = 0; rcv = 0; cyc = 0; stall_prev = 1'b0; hold_val = '0;
        while (rcv < 1000 && cyc < 8000) begin
            readyIn = ($urandom_range(1, 0) == 1);
            validIn = (sent < 1000) && ($urandom_range(3, 0) != 0);
            sofIn   = (sent % 100 == 0);
            nr = 4'($urandom); ng = 4'($urandom); nb = 4'($urandom);
            rIn = nr; gIn = ng; bIn = nb;
            #1;
            if (stall_prev) begin
                check("bp_hold", {validOut, sofOut, rOut, gOut, bOut}, {1'b1, hold_val});
            end
            if (!readyOut) begin
                check("bp_ready_low_cause", {validOut, readyIn}, 32'h2);
            end
            if (validOut && readyIn) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra_pixel", validOut, 32'h0);
                end else begin
                    check("bp_data", {sofOut, rOut, gOut, bOut}, exp_q.pop_front());
                end
                rcv++;
            end
            stall_prev = validOut && !readyIn;
            hold_val   = {sofOut, rOut, gOut, bOut};
            if (validIn && readyOut) begin
                exp_q.push_back({sofIn, nr, ~ng, nb});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle(); readyIn = 1'b1;
        check("bp_received_all", rcv, 32'd1000);
        check("bp_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        check("bp_drained", validOut, 32'h0);
        check("bp_frame_count", frameCount, 32'd10);

        // ---- wide channels and frame counter wrap ----
        w_in[0] = 8'h00; w_in[1] = 8'h12; w_in[2] = 8'h34; w_in[3] = 8'h56; w_in[4] = 8'hFF;
        w_exp[0] = 8'hFF; w_exp[1] = 8'hED; w_exp[2] = 8'hCB; w_exp[3] = 8'hA9; w_exp[4] = 8'h00;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                validIn2 = 1'b1; sofIn2 = 1'b1;
                cfgLoad2 = (i == 0); modeIn2 = 2'd2; colorSelect2 = 3'b111;
                rIn2 = w_in[i]; gIn2 = w_in[i]; bIn2 = w_in[i];
            end else begin
                validIn2 = 1'b0; sofIn2 = 1'b0; cfgLoad2 = 1'b0;
            end
            #1;
            if (i >= 2) begin
                check("wide_invert", {validOut2, rOut2, gOut2, bOut2},
                      {1'b1, w_exp[i-2], w_exp[i-2], w_exp[i-2]});
            end
            @(posedge clk); #1;
            if (i < 5) begin
                check("narrow_frame_count", frameCount2, 32'((i + 1) % 4));
            end
        end
        check("frame_count_wrap_final", frameCount2, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
